// File: rtl/retire_recovery_ctrl_pkg.sv
// retire_recovery_ctrl_pkg: shared widths, retire FSM states and the ROB head entry bundle.
package retire_recovery_ctrl_pkg;
  localparam int WAYS = 3;
  localparam int PR_W = 6;
  localparam int AR_W = 5;
  localparam int XLEN = 32;
  localparam int RESTORE_CYCLES = 2;
  localparam int CNT_W = RESTORE_CYCLES > 1 ? $clog2(RESTORE_CYCLES) : 1;

  typedef enum logic [1:0] {NORMAL, SQUASH, RESTORE, HALT} retire_state_e;

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic            mispredict;
    logic            halt;
    logic [XLEN-1:0] target_pc;
    logic [PR_W-1:0] t_idx;
    logic [PR_W-1:0] told_idx;
    logic [AR_W-1:0] ar_idx;
  } rob_head_entry_t;
endpackage

// File: rtl/retire_recovery_ctrl_select.sv
// retire_recovery_ctrl_select: oldest-first contiguous retire group, arch-map/freelist enables and the first retiring event.
module retire_recovery_ctrl_select
  import retire_recovery_ctrl_pkg::*;
(
  input  rob_head_entry_t [WAYS-1:0] head_i,
  input  logic                       en_i,
  input  logic                       stall_i,
  output logic [WAYS-1:0]            retire_en_o,
  output logic [WAYS-1:0]            arch_wr_en_o,
  output logic [WAYS-1:0]            free_en_o,
  output logic                       ev_valid_o,
  output logic                       ev_mis_o,
  output logic [XLEN-1:0]            ev_pc_o
);
  logic go;

  always_comb begin
    retire_en_o  = '0;
    arch_wr_en_o = '0;
    free_en_o    = '0;
    ev_valid_o   = 1'b0;
    ev_mis_o     = 1'b0;
    ev_pc_o      = '0;
    go           = en_i & ~stall_i;
    // A mispredict/halt retires itself but closes the group behind it.
    for (int i = 0; i < WAYS; i++) begin
      retire_en_o[i] = go & head_i[i].valid & head_i[i].complete;
      go = retire_en_o[i] & ~head_i[i].mispredict & ~head_i[i].halt;
      if (retire_en_o[i] && (head_i[i].mispredict || head_i[i].halt)) begin
        ev_valid_o = 1'b1;
        ev_mis_o   = head_i[i].mispredict;
        ev_pc_o    = head_i[i].target_pc;
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      free_en_o[i]    = retire_en_o[i] & (|head_i[i].ar_idx);
      arch_wr_en_o[i] = free_en_o[i];
      for (int k = i + 1; k < WAYS; k++)
        if (retire_en_o[k] && head_i[k].ar_idx == head_i[i].ar_idx) arch_wr_en_o[i] = 1'b0;
    end
  end
endmodule

// File: rtl/retire_recovery_ctrl.sv
// retire_recovery_ctrl: in-order retirement sequencing plus the squash/restore/halt recovery FSM.
module retire_recovery_ctrl
  import retire_recovery_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WAYS-1:0]        head_valid_i,
  input  logic [WAYS-1:0]        head_complete_i,
  input  logic [WAYS-1:0]        head_mispredict_i,
  input  logic [WAYS-1:0]        head_halt_i,
  input  logic [WAYS*XLEN-1:0]   head_target_pc_i,
  input  logic [WAYS*PR_W-1:0]   head_t_idx_i,
  input  logic [WAYS*PR_W-1:0]   head_told_idx_i,
  input  logic [WAYS*AR_W-1:0]   head_ar_idx_i,
  input  logic                   retire_stall_i,
  output logic [WAYS-1:0]        retire_en_o,
  output logic [1:0]             retire_cnt_o,
  output logic [WAYS-1:0]        arch_wr_en_o,
  output logic [WAYS-1:0]        free_en_o,
  output logic                   squash_o,
  output logic                   br_recover_enable_o,
  output logic [XLEN-1:0]        target_pc_o,
  output logic                   dispatch_hold_o,
  output logic                   halted_o
);
  rob_head_entry_t [WAYS-1:0] head;
  retire_state_e              state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [XLEN-1:0]            pc_q, pc_d;
  logic                       ev_valid, ev_mis;
  logic [XLEN-1:0]            ev_pc;
  logic                       unused_head;

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      head[i].valid      = head_valid_i[i];
      head[i].complete   = head_complete_i[i];
      head[i].mispredict = head_mispredict_i[i];
      head[i].halt       = head_halt_i[i];
      head[i].target_pc  = head_target_pc_i[i*XLEN +: XLEN];
      head[i].t_idx      = head_t_idx_i[i*PR_W +: PR_W];
      head[i].told_idx   = head_told_idx_i[i*PR_W +: PR_W];
      head[i].ar_idx     = head_ar_idx_i[i*AR_W +: AR_W];
    end
  end

  // Physical tags only travel alongside the enables to the map table and freelist.
  assign unused_head = ^head;

  retire_recovery_ctrl_select u_select (
    .head_i       (head),
    .en_i         (rst_ni && state_q == NORMAL),
    .stall_i      (retire_stall_i),
    .retire_en_o  (retire_en_o),
    .arch_wr_en_o (arch_wr_en_o),
    .free_en_o    (free_en_o),
    .ev_valid_o   (ev_valid),
    .ev_mis_o     (ev_mis),
    .ev_pc_o      (ev_pc)
  );

  always_comb begin
    retire_cnt_o = '0;
    for (int i = 0; i < WAYS; i++) retire_cnt_o = retire_cnt_o + 2'(retire_en_o[i]);
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    pc_d                = pc_q;
    squash_o            = 1'b0;
    br_recover_enable_o = 1'b0;
    target_pc_o         = '0;
    dispatch_hold_o     = 1'b0;
    halted_o            = 1'b0;
    case (state_q)
      NORMAL: begin
        if (ev_valid) state_d = ev_mis ? SQUASH : HALT;
        pc_d = ev_valid && ev_mis ? ev_pc : pc_q;
      end
      SQUASH: begin
        squash_o        = 1'b1;
        target_pc_o     = pc_q;
        dispatch_hold_o = 1'b1;
        cnt_d           = '0;
        state_d         = RESTORE;
      end
      RESTORE: begin
        br_recover_enable_o = 1'b1;
        dispatch_hold_o     = 1'b1;
        cnt_d               = cnt_q == CNT_W'(RESTORE_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d             = cnt_q == CNT_W'(RESTORE_CYCLES - 1) ? NORMAL : RESTORE;
      end
      default: begin
        halted_o        = 1'b1;
        dispatch_hold_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end
endmodule

// File: tb/tb_retire_recovery_ctrl.sv
// tb_retire_recovery_ctrl: directed and random retirement traffic checked against a behavioural model.
module tb_retire_recovery_ctrl;
  localparam int RC = 2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hv, hc, hm, hh;
  logic [95:0] hpc;
  logic [17:0] ht, hto;
  logic [14:0] har;
  logic        stall;
  logic [2:0]  ret, wr, fr;
  logic [1:0]  cnt;
  logic        sq, br, hold, hlt;
  logic [31:0] tpc;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          m_halted;
  int          post_q[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  retire_recovery_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .head_valid_i(hv), .head_complete_i(hc), .head_mispredict_i(hm), .head_halt_i(hh),
    .head_target_pc_i(hpc), .head_t_idx_i(ht), .head_told_idx_i(hto), .head_ar_idx_i(har),
    .retire_stall_i(stall),
    .retire_en_o(ret), .retire_cnt_o(cnt), .arch_wr_en_o(wr), .free_en_o(fr),
    .squash_o(sq), .br_recover_enable_o(br), .target_pc_o(tpc),
    .dispatch_hold_o(hold), .halted_o(hlt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_way(input int i, input bit v, input bit c, input bit m, input bit h,
                         input logic [4:0] ar, input logic [31:0] pc);
    hv[i] = v; hc[i] = c; hm[i] = m; hh[i] = h;
    har[i*5 +: 5] = ar;
    hpc[i*32 +: 32] = pc;
    ht[i*6 +: 6] = 6'($urandom);
    hto[i*6 +: 6] = 6'($urandom);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_ret, input logic [2:0] e_wr,
                         input logic [2:0] e_fr, input bit e_sq, input bit e_br,
                         input logic [31:0] e_pc, input bit e_hold, input bit e_hlt);
    chk({tag, ".retire_en"}, 32'(ret), 32'(e_ret));
    chk({tag, ".retire_cnt"}, 32'(cnt), $countones(e_ret));
    chk({tag, ".arch_wr_en"}, 32'(wr), 32'(e_wr));
    chk({tag, ".free_en"}, 32'(fr), 32'(e_fr));
    chk({tag, ".squash"}, 32'(sq), 32'(e_sq));
    chk({tag, ".br_recover"}, 32'(br), 32'(e_br));
    chk({tag, ".target_pc"}, tpc, e_pc);
    chk({tag, ".dispatch_hold"}, 32'(hold), 32'(e_hold));
    chk({tag, ".halted"}, 32'(hlt), 32'(e_hlt));
  endtask

  // mode: 0 normal, 1 squash cycle, 2 restore cycle, 3 halted
  task automatic run_cycle(input string tag);
    logic [2:0] e_ret, e_wr, e_fr;
    logic [31:0] ev_pc;
    bit seen[32];
    bit go, ev, ev_mis;
    int mode;
    #1;
    e_ret = '0; e_wr = '0; e_fr = '0; ev = 0; ev_mis = 0; ev_pc = '0;
    mode = m_halted ? 3 : (post_q.size() != 0 ? post_q[0] : 0);
    go = mode == 0 && !stall;
    for (int i = 0; i < 3; i++) begin
      if (go && hv[i] && hc[i]) begin
        e_ret[i] = 1'b1;
        if (hm[i] || hh[i]) begin
          ev = 1; ev_mis = hm[i]; ev_pc = hpc[i*32 +: 32]; go = 0;
        end
      end else go = 0;
    end
    for (int i = 2; i >= 0; i--) begin
      if (e_ret[i] && har[i*5 +: 5] != 0) begin
        e_fr[i] = 1'b1;
        e_wr[i] = !seen[har[i*5 +: 5]];
        seen[har[i*5 +: 5]] = 1;
      end
    end
    chk_all(tag, e_ret, e_wr, e_fr, mode == 1, mode == 2, mode == 1 ? m_pc : 32'h0,
            mode != 0, mode == 3);
    @(posedge clk);
    #1;
    if (post_q.size() != 0) void'(post_q.pop_front());
    else if (mode == 0 && ev && ev_mis) begin
      m_pc = ev_pc;
      post_q.push_back(1);
      for (int r = 0; r < RC; r++) post_q.push_back(2);
    end else if (mode == 0 && ev) m_halted = 1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_all(tag, 3'b000, 3'b000, 3'b000, 0, 0, 32'h0, 0, 0);
    post_q.delete();
    m_halted = 0;
    m_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic all_done(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    set_way(0, 1, 1, 0, 0, a0, 32'h100);
    set_way(1, 1, 1, 0, 0, a1, 32'h104);
    set_way(2, 1, 1, 0, 0, a2, 32'h108);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    hv = '0; hc = '0; hm = '0; hh = '0; hpc = '0; ht = '0; hto = '0; har = '0;
    #12;
    all_done(17, 18, 19);
    do_reset("reset_init");
    run_cycle("after_reset");
    all_done(17, 18, 19);
    run_cycle("all_retire");
    hc = 3'b101;
    run_cycle("hole_complete");
    stall = 1'b1;
    run_cycle("stall");
    stall = 1'b0;
    all_done(5, 5, 0);
    run_cycle("same_ar");
    all_done(1, 2, 3);
    hv = 3'b101;
    run_cycle("valid_hole");
    all_done(1, 2, 3);
    set_way(1, 1, 1, 1, 0, 2, 32'h400);
    run_cycle("mispredict_way1");
    stall = 1'b1;
    for (int i = 0; i < 1 + RC; i++) run_cycle("recovery");
    stall = 1'b0;
    all_done(4, 4, 4);
    run_cycle("resume");
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++)
        set_way(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, 0, 5'($urandom_range(0, 7)), $urandom);
      stall = $urandom_range(0, 7) == 0;
      run_cycle("random");
    end
    stall = 1'b0;
    all_done(1, 2, 3);
    set_way(0, 1, 1, 1, 0, 9, 32'h8000);
    run_cycle("mispredict_way0");
    run_cycle("squash2");
    all_done(1, 2, 3);
    do_reset("reset_mid_restore");
    run_cycle("normal_after_reset");
    all_done(6, 7, 8);
    set_way(0, 1, 1, 0, 1, 6, 32'h200);
    set_way(2, 1, 1, 1, 0, 8, 32'h300);
    run_cycle("halt_way0");
    for (int i = 0; i < 4; i++) begin
      all_done(1, 2, 3);
      hm = 3'($urandom);
      run_cycle("halted");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
